// File: rtl/rh_note_highway.sv
// Scrolling note highway: ring-buffered note stream, tempo-driven scroll,
// two-stage pixel pipeline with matching delayed raster syncs.
module rh_note_highway #(
   parameter int          NSLOTS        = 16,
   parameter int          NOTE_W_LOG2   = 6,
   parameter int          NOTE_HEIGHT   = 24,
   parameter int          LANE_PITCH    = 32,
   parameter int          FIRST_LANE_Y  = 550,
   parameter int          ACTION_X      = 72,
   parameter int          DEFAULT_TEMPO = 32_500_000,
   parameter logic [23:0] NOTE_COLOR    = 24'hFFFFFF,
   parameter logic [23:0] SHARP_COLOR   = 24'h5555FF,
   parameter logic [23:0] HIGH_COLOR    = 24'h00DD00,
   parameter logic [23:0] HIT_COLOR     = 24'hFFFF00
) (
   input  logic        vclock,
   input  logic        reset,
   input  logic [3:0]  note_in,
   input  logic        note_valid,
   output logic        note_ready,
   input  logic [25:0] tempo,
   input  logic        tempo_load,
   input  logic        pause,
   input  logic        playing_correct,
   input  logic [10:0] hcount,
   input  logic [9:0]  vcount,
   input  logic        hsync,
   input  logic        vsync,
   input  logic        blank,
   output logic        phsync,
   output logic        pvsync,
   output logic        pblank,
   output logic [23:0] pixel,
   output logic [3:0]  head_note,
   output logic        beat,
   output logic        underflow
);

   localparam int PW = $clog2(NSLOTS);
   localparam int CW = PW + 1;
   localparam int OW = NOTE_W_LOG2;
   localparam logic [25:0] DEF_RAW = 26'(DEFAULT_TEMPO >> NOTE_W_LOG2);
   localparam logic [25:0] DEF_PER = (DEF_RAW == 26'd0) ? 26'd1 : DEF_RAW;

   logic [3:0]    buf_q [NSLOTS];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [OW-1:0] offset_q, offset_d, disp_q, disp_d;
   logic [25:0]   step_cnt_q, step_cnt_d, step_per_q, step_per_d;
   logic          beat_q, unf_q, unf_d;
   logic          push, step, wrap, pop;
   logic [25:0]   load_per;

   assign note_ready = count_q < CW'(NSLOTS);
   assign push       = note_valid && note_ready;
   assign step       = !tempo_load && !pause && (step_cnt_q == step_per_q - 26'd1);
   assign wrap       = step && (offset_q == {OW{1'b1}});
   assign pop        = wrap && (count_q != '0);
   assign load_per   = tempo >> NOTE_W_LOG2;
   assign head_note  = (count_q != '0) ? buf_q[rd_ptr_q] : 4'd0;
   assign beat       = beat_q;
   assign underflow  = unf_q;

   always_comb begin
      wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d    = count_q + CW'(push) - CW'(pop);
      unf_d      = unf_q | (wrap && (count_q == '0));
      step_per_d = step_per_q;
      step_cnt_d = step_cnt_q;
      offset_d   = offset_q;
      disp_d     = ((hcount == 11'd0) && (vcount == 10'd0)) ? offset_q : disp_q;
      // A tempo change restarts the beat from scratch and suppresses any step
      if (tempo_load) begin
         step_per_d = (load_per == 26'd0) ? 26'd1 : load_per;
         step_cnt_d = '0;
         offset_d   = '0;
      end else if (!pause) begin
         step_cnt_d = step ? 26'd0 : step_cnt_q + 26'd1;
         offset_d   = step ? offset_q + 1'b1 : offset_q;
      end
   end

   always_ff @(posedge vclock) begin
      if (push) buf_q[wr_ptr_q] <= note_in;
   end

   always_ff @(posedge vclock or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         offset_q   <= '0;
         disp_q     <= '0;
         step_cnt_q <= '0;
         step_per_q <= DEF_PER;
         beat_q     <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         offset_q   <= offset_d;
         disp_q     <= disp_d;
         step_cnt_q <= step_cnt_d;
         step_per_q <= step_per_d;
         beat_q     <= wrap;
         unf_q      <= unf_d;
      end
   end

   logic [11:0]   rel, slot_full;
   logic          inx_d, act_d;
   logic [PW-1:0] slot_q;
   logic          inx_q, act_q, hs1_q, vs1_q, bl1_q;
   logic [9:0]    vc1_q;

   assign rel       = {1'b0, hcount} - 12'(ACTION_X) + 12'(disp_q);
   assign slot_full = rel >> NOTE_W_LOG2;
   assign inx_d     = (hcount > 11'(ACTION_X)) && (slot_full < 12'(NSLOTS));
   assign act_d     = (hcount == 11'(ACTION_X)) && (vcount >= 10'(FIRST_LANE_Y));

   always_ff @(posedge vclock or posedge reset) begin
      if (reset) begin
         slot_q <= '0;
         inx_q  <= 1'b0;
         act_q  <= 1'b0;
         vc1_q  <= '0;
         hs1_q  <= 1'b0;
         vs1_q  <= 1'b0;
         bl1_q  <= 1'b0;
      end else begin
         slot_q <= slot_full[PW-1:0];
         inx_q  <= inx_d;
         act_q  <= act_d;
         vc1_q  <= vcount;
         hs1_q  <= hsync;
         vs1_q  <= vsync;
         bl1_q  <= blank;
      end
   end

   logic [PW-1:0] idx;
   logic [3:0]    code;
   logic [2:0]    lane;
   logic [10:0]   lane_y, vc11;
   logic [23:0]   col, pix_d;
   logic          in_y;

   assign idx  = rd_ptr_q + slot_q;
   assign code = ({1'b0, slot_q} < count_q) ? buf_q[idx] : 4'd0;
   assign vc11 = {1'b0, vc1_q};

   always_comb begin
      lane = 3'd0;
      col  = NOTE_COLOR;
      unique case (code)
         4'd1, 4'd2:   lane = 3'd6;
         4'd3, 4'd4:   lane = 3'd5;
         4'd5:         lane = 3'd4;
         4'd6, 4'd7:   lane = 3'd3;
         4'd8, 4'd9:   lane = 3'd2;
         4'd10, 4'd11: lane = 3'd1;
         4'd13:        lane = 3'd6;
         default:      lane = 3'd0;
      endcase
      unique case (code)
         4'd0:                             col = 24'h0;
         4'd2, 4'd4, 4'd7, 4'd9, 4'd11:    col = SHARP_COLOR;
         4'd13:                            col = HIGH_COLOR;
         default:                          col = NOTE_COLOR;
      endcase
      if ((slot_q == '0) && playing_correct && (code != 4'd0)) col = HIT_COLOR;
      lane_y = 11'(FIRST_LANE_Y) + 11'(LANE_PITCH) * {8'd0, lane};
      in_y   = (vc11 >= lane_y) && (vc11 < lane_y + 11'(NOTE_HEIGHT));
      pix_d  = ((inx_q && in_y) ? col : 24'h0) | {24{act_q}};
      if (bl1_q) pix_d = 24'h0;
   end

   always_ff @(posedge vclock or posedge reset) begin
      if (reset) begin
         pixel  <= '0;
         phsync <= 1'b0;
         pvsync <= 1'b0;
         pblank <= 1'b0;
      end else begin
         pixel  <= pix_d;
         phsync <= hs1_q;
         pvsync <= vs1_q;
         pblank <= bl1_q;
      end
   end

endmodule

// File: tb/tb_rh_note_highway.sv
// Scoreboard bench for rh_note_highway: beat and pixel expectations are
// queued by the stimulus and retired by an independent output monitor.
module tb_rh_note_highway;

   logic        vclock = 1'b0;
   logic        reset;
   logic [3:0]  note_in;
   logic        note_valid, note_ready;
   logic [25:0] tempo;
   logic        tempo_load, pause, playing_correct;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic        hsync, vsync, blank;
   logic        phsync, pvsync, pblank;
   logic [23:0] pixel;
   logic [3:0]  head_note;
   logic        beat, underflow;

   rh_note_highway dut (
      .vclock(vclock), .reset(reset),
      .note_in(note_in), .note_valid(note_valid), .note_ready(note_ready),
      .tempo(tempo), .tempo_load(tempo_load), .pause(pause),
      .playing_correct(playing_correct),
      .hcount(hcount), .vcount(vcount),
      .hsync(hsync), .vsync(vsync), .blank(blank),
      .phsync(phsync), .pvsync(pvsync), .pblank(pblank),
      .pixel(pixel), .head_note(head_note), .beat(beat), .underflow(underflow)
   );

   always #5 vclock = ~vclock;

   typedef struct { string nm; int cyc; logic [3:0] head; } beat_t;
   typedef struct { string nm; logic [26:0] exp; } pix_t;
   beat_t bq[$];
   pix_t  pq[$];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit probe   = 1'b0;
   bit pv1     = 1'b0;
   bit pv2     = 1'b0;
   int L, X, c;

   always @(posedge vclock) begin
      cyc <= cyc + 1;
      pv1 <= probe;
      pv2 <= pv1;
   end

   always @(negedge vclock) begin
      if (!reset) begin
         if (beat) begin
            n_tests++;
            if (bq.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_beat: beat at cycle %0d, none required", cyc);
            end else begin
               beat_t b;
               b = bq.pop_front();
               if (cyc != b.cyc || head_note !== b.head) begin
                  n_fail++;
                  $display("FAIL %s: cycle %0d head %0d, required cycle %0d head %0d",
                           b.nm, cyc, head_note, b.cyc, b.head);
               end
            end
         end
         if (pv2) begin
            n_tests++;
            if (pq.size() == 0) begin
               n_fail++;
               $display("FAIL stray_pixel: probe output with empty queue");
            end else begin
               pix_t p;
               logic [26:0] act;
               p   = pq.pop_front();
               act = {phsync, pvsync, pblank, pixel};
               if (act !== p.exp) begin
                  n_fail++;
                  $display("FAIL %s: got %h required %h", p.nm, act, p.exp);
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic till(input int t);
      while (cyc < t) @(negedge vclock);
   endtask

   task automatic wait_q(input int maxc);
      int k = 0;
      while (bq.size() != 0 && k < maxc) begin
         @(negedge vclock);
         k++;
      end
      if (bq.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL beat_timeout: %0d beats still pending, required 0", bq.size());
         bq.delete();
      end
   endtask

   task automatic px(input string nm, input int h, input int v,
                     input logic [2:0] sy, input logic [23:0] exp);
      hcount = 11'(h);
      vcount = 10'(v);
      {hsync, vsync, blank} = sy;
      probe = 1'b1;
      pq.push_back('{nm, {sy, exp}});
      @(negedge vclock);
   endtask

   task automatic px_idle();
      hcount = 11'd1000;
      vcount = 10'd0;
      {hsync, vsync, blank} = 3'b000;
      probe = 1'b0;
      repeat (3) @(negedge vclock);
   endtask

   initial begin
      reset = 1'b1;
      note_in = 4'd0; note_valid = 1'b0;
      tempo = 26'd0; tempo_load = 1'b0;
      pause = 1'b0; playing_correct = 1'b0;
      hcount = 11'd1000; vcount = 10'd0;
      hsync = 1'b0; vsync = 1'b0; blank = 1'b0;
      repeat (3) @(negedge vclock);
      reset = 1'b0;
      @(negedge vclock);
      chk("rst_ready", 32'(note_ready), 32'd1);
      chk("rst_head", 32'(head_note), 32'd0);
      chk("rst_beat", 32'(beat), 32'd0);
      chk("rst_underflow", 32'(underflow), 32'd0);
      chk("rst_pixel", 32'(pixel), 32'd0);
      chk("rst_syncs", 32'({phsync, pvsync, pblank}), 32'd0);

      // load tempo 640 (period 10) then push 12,5,1
      tempo = 26'd640; tempo_load = 1'b1;
      L = cyc + 1;
      bq.push_back('{"beat1", L + 640, 4'd5});
      bq.push_back('{"beat2", L + 1280, 4'd1});
      @(negedge vclock);
      tempo_load = 1'b0;
      note_valid = 1'b1;
      note_in = 4'd12; @(negedge vclock);
      note_in = 4'd5;  @(negedge vclock);
      note_in = 4'd1;  @(negedge vclock);
      note_valid = 1'b0;
      chk("head_after_push", 32'(head_note), 32'd12);
      chk("ready_after_push", 32'(note_ready), 32'd1);

      // 1000-cycle pause mid-beat delays the third beat
      bq.push_back('{"beat3_paused", L + 2920, 4'd0});
      bq.push_back('{"beat4_empty", L + 3560, 4'd0});
      till(L + 1500);
      pause = 1'b1;
      repeat (1000) @(negedge vclock);
      pause = 1'b0;
      till(L + 2921);
      chk("no_underflow_yet", 32'(underflow), 32'd0);
      wait_q(3000);
      chk("underflow_set", 32'(underflow), 32'd1);
      chk("head_empty", 32'(head_note), 32'd0);

      px("empty_slot0", 100, 690, 3'b000, 24'h000000);
      px("empty_action", 72, 600, 3'b000, 24'hFFFFFF);
      px_idle();

      // reload, freeze, latch disp_offset=0, fill 16 notes
      tempo_load = 1'b1;
      @(negedge vclock);
      tempo_load = 1'b0;
      pause = 1'b1;
      hcount = 11'd0; vcount = 10'd0;
      note_valid = 1'b1; note_in = 4'd5;
      @(negedge vclock);
      hcount = 11'd1000;
      for (int i = 1; i < 16; i++) begin
         note_in = 4'(i);
         @(negedge vclock);
      end
      chk("full_ready", 32'(note_ready), 32'd0);
      note_in = 4'd9;
      @(negedge vclock);
      note_valid = 1'b0;
      chk("ignored_17th_ready", 32'(note_ready), 32'd0);
      chk("ignored_17th_head", 32'(head_note), 32'd5);

      px("slot0_left", 73, 678, 3'b000, 24'hFFFFFF);
      px("slot0_right", 135, 701, 3'b000, 24'hFFFFFF);
      px("slot0_below", 135, 702, 3'b000, 24'h000000);
      px("slot0_above", 135, 677, 3'b000, 24'h000000);
      px("action_line", 72, 600, 3'b000, 24'hFFFFFF);
      px("action_above", 72, 549, 3'b000, 24'h000000);
      px("slot1_wrong_lane", 136, 678, 3'b000, 24'h000000);
      px("slot1_c", 136, 742, 3'b000, 24'hFFFFFF);
      px("slot1_corner", 199, 765, 3'b000, 24'hFFFFFF);
      px("slot2_sharp", 200, 750, 3'b000, 24'h5555FF);
      px("blanked", 73, 680, 3'b001, 24'h000000);
      px("sync_delay", 73, 680, 3'b110, 24'hFFFFFF);
      px("slot12_b", 841, 550, 3'b000, 24'hFFFFFF);
      px("slot13_highc", 909, 742, 3'b000, 24'h00DD00);
      px("slot15_other", 1033, 550, 3'b000, 24'hFFFFFF);
      px("past_last_slot", 1097, 550, 3'b000, 24'h000000);
      px_idle();
      playing_correct = 1'b1;
      px("hit_slot0", 100, 690, 3'b000, 24'hFFFF00);
      px("hit_not_slot1", 150, 750, 3'b000, 24'hFFFFFF);
      px_idle();
      playing_correct = 1'b0;

      // resume: pop, then refill in the following cycle
      pause = 1'b0;
      c = cyc;
      X = c + 640;
      bq.push_back('{"beat_refill_pop", X, 4'd1});
      till(X);
      chk("ready_after_pop", 32'(note_ready), 32'd1);
      note_valid = 1'b1; note_in = 4'd7;
      @(negedge vclock);
      note_valid = 1'b0;
      chk("refilled_full", 32'(note_ready), 32'd0);

      // tempo_load lands on the offset=63 step: no pop, restart at period 20
      bq.push_back('{"beat_after_reload", X + 1920, 4'd2});
      till(X + 639);
      tempo = 26'd1280; tempo_load = 1'b1;
      @(negedge vclock);
      tempo_load = 1'b0;
      wait_q(3000);
      chk("underflow_sticky", 32'(underflow), 32'd1);
      chk("pix_queue_drained", 32'(pq.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rh_note_highway.md
Name: rh_note_highway

Overview:
Parametrised successor to the single-track note display. It buffers an incoming note stream in an NSLOTS-deep ring buffer and scrolls the notes leftward toward the action line at a tempo-derived rate. It renders a pipelined pixel stream with matching delayed syncs. It sits between the song sequencer (note source) and the XVGA output mux.

Parameters:
NSLOTS, 16, ring-buffer depth and number of visible slots; power of 2, range 2..32
NOTE_W_LOG2, 6, log2 of note width in pixels (note width W = 64)
NOTE_HEIGHT, 24, note height in pixels
LANE_PITCH, 32, vertical distance between adjacent pitch lanes
FIRST_LANE_Y, 550, y coordinate of the top lane (B)
ACTION_X, 72, x coordinate of the action line
DEFAULT_TEMPO, 32_500_000, vclock cycles per beat applied at reset
NOTE_COLOR/SHARP_COLOR/HIGH_COLOR/HIT_COLOR, FFFFFF/5555FF/00DD00/FFFF00, colours for natural, sharp, high-C and hit notes

Ports:
vclock  in  1  pixel clock
reset  in  1  asynchronous, active-high
note_in  in  4  note code (0 = rest, 1..13 as in the pitch table)
note_valid  in  1  note_in is valid
note_ready  out  1  buffer can accept a note
tempo  in  26  vclock cycles per beat
tempo_load  in  1  one-cycle strobe that latches tempo
pause  in  1  freezes scrolling
playing_correct  in  1  player is hitting the head note
hcount, vcount  in  11, 10  raster position
hsync, vsync, blank  in  1 each  raster timing
phsync, pvsync, pblank  out  1 each  timing signals delayed 2 cycles
pixel  out  24  RGB, latency 2
head_note  out  4  code in slot 0 (0 when the buffer is empty)
beat  out  1  one-cycle pulse on each pop
underflow  out  1  sticky; set when a pop occurs with the buffer empty

Behaviour:
- Reset values: buffer empty, count=0, rd_ptr=wr_ptr=0, offset=0, disp_offset=0, step_cnt=0, step_period=max(DEFAULT_TEMPO>>NOTE_W_LOG2, 1), all outputs 0 except note_ready=1.
- Push: a push occurs when note_valid&&note_ready. note_ready = (count<NSLOTS). The note is written at wr_ptr, then wr_ptr increments modulo NSLOTS.
- Step: when pause=0, step_cnt counts from 0 to step_period-1 and then wraps. Each wrap is one step.
  - On a step with offset<W-1: offset increments by 1.
  - On a step with offset=W-1: offset is set to 0, a pop occurs, and beat=1 for that cycle.
- Pop: if count>0, rd_ptr increments and count decrements. If count=0, rd_ptr is unchanged, underflow is set to 1, and slot 0 remains a rest.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- tempo_load: step_period is set to max(tempo>>NOTE_W_LOG2, 1). step_cnt and offset are cleared. Buffer contents are preserved. If tempo_load coincides with a step, tempo_load wins and no step or pop occurs.
- pause=1: step_cnt and offset hold. Pushes are still accepted.
- Frame latch: disp_offset is updated from offset only on cycles where hcount==0 && vcount==0, so there is no tearing within a frame.
- Slot k (0..NSLOTS-1) holds buffer[rd_ptr+k] if k<count, otherwise a rest.
- Pixel pipeline, stage 1:
  - rel = hcount - ACTION_X + disp_offset, computed at 12 bits.
  - slot = rel>>NOTE_W_LOG2.
  - in_x = (hcount>ACTION_X) && (slot<NSLOTS).
  - vcount, the action-line flag and the syncs are registered alongside.
- Pixel pipeline, stage 2:
  - Look up the note code for the slot and its lane y.
  - Lane y = FIRST_LANE_Y + LANE_PITCH*lane, where lane is: C,C#=6; D,D#=5; E=4; F,F#=3; G,G#=2; A,A#=1; B=0; high C=6; other codes=0.
  - Colour: rest=0; codes 2,4,7,9,11 use SHARP_COLOR; code 13 uses HIGH_COLOR; all others use NOTE_COLOR.
  - If slot==0, playing_correct=1 and the code is non-zero, the colour is HIT_COLOR.
  - The note pixel is the colour when in_x && y<=vcount<y+NOTE_HEIGHT, otherwise 0.
  - pixel = note pixel | {24{action_line}}, where action_line = (hcount==ACTION_X && vcount>=FIRST_LANE_Y).
  - pixel is forced to 0 when the delayed blank is 1.
- Async reset asserted mid-frame clears the pipeline immediately. Output resumes with correct alignment 2 cycles after reset deasserts.

Test Plan:
- Reset, then push codes 12,5,1 with tempo_load tempo=640 (step_period=10) -> note_ready=1, head_note=12, count=3. beat pulses every 640 cycles. head_note becomes 5 after the first beat.
- Push 16 notes with no pops -> note_ready=0 after the 16th push. A 17th note_valid is ignored. A push in the cycle after a pop is accepted and count returns to 16.
- Let the buffer drain past empty -> on the next beat underflow=1 and stays 1. head_note=0 and no note pixels are drawn.
- pause=1 for 1000 cycles mid-beat -> offset and step_cnt hold and beat is delayed by exactly 1000 cycles.
- Raster check, disp_offset=0, slot0=code 5 -> pixel=FFFFFF at hcount 73..135, vcount 678..701 (lane 4). The action line is white at hcount 72, vcount>=550. Output latency is 2 cycles relative to hcount. With playing_correct=1 the slot-0 pixels become FFFF00.
- tempo_load asserted in the same cycle as a step when offset=63 -> no pop, no beat, offset=0. The next pop occurs 64 steps later at the new period.
